// File: rtl/ip_tx_arbiter.sv
// ip_tx_arbiter: round-robin arbiter that shares one ip_packet_tx engine among NUM_REQ requesters.
// It latches the winner's fields, pulses START_IP_TXN, tracks READY_FOR_SEND and reports completion.
`default_nettype none

module ip_tx_arbiter #(
  parameter int NUM_REQ      = 2,
  parameter int BUSY_TIMEOUT = 16,
  localparam int GW          = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                    ACLK,
  input  logic                    ARESET,
  input  logic                    ARB_ENABLE,
  input  logic [NUM_REQ-1:0]      REQ_VALID,
  input  logic [32*NUM_REQ-1:0]   REQ_IP_ADDRESS,
  input  logic [48*NUM_REQ-1:0]   REQ_MAC_ADDRESS,
  input  logic [10*NUM_REQ-1:0]   REQ_MESSAGE,
  output logic [NUM_REQ-1:0]      REQ_ACCEPT,
  output logic [NUM_REQ-1:0]      REQ_DONE,
  output logic [31:0]             RECIPIENT_IP_ADDRESS,
  output logic [47:0]             RECIPIENT_MAC_ADDRESS,
  output logic [9:0]              RECIPIENT_MESSAGE,
  output logic                    START_IP_TXN,
  input  logic                    READY_FOR_SEND,
  output logic [GW-1:0]           GRANT_ID,
  output logic                    ARB_BUSY,
  output logic                    TX_ERROR
);

  localparam int CW = (BUSY_TIMEOUT > 2) ? $clog2(BUSY_TIMEOUT) : 1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  state_t               state, state_nxt;
  logic [GW-1:0]        last_grant, last_grant_nxt;
  logic [GW-1:0]        grant, grant_nxt;
  logic [CW-1:0]        cnt, cnt_nxt;
  logic [NUM_REQ-1:0]   accept, accept_nxt;
  logic [NUM_REQ-1:0]   done, done_nxt;
  logic                 start, start_nxt;
  logic [31:0]          rcp_ip, rcp_ip_nxt;
  logic [47:0]          rcp_mac, rcp_mac_nxt;
  logic [9:0]           rcp_msg, rcp_msg_nxt;
  logic                 tx_err, tx_err_nxt;
  logic                 win_found;
  logic [GW-1:0]        win;

  // Search starts just after the last owner, so the previous winner ranks last.
  always_comb begin
    win_found = 1'b0;
    win       = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!win_found && REQ_VALID[(int'(last_grant) + k) % NUM_REQ]) begin
        win_found = 1'b1;
        win       = GW'((int'(last_grant) + k) % NUM_REQ);
      end
    end
  end

  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    grant_nxt      = grant;
    cnt_nxt        = cnt;
    accept_nxt     = '0;
    done_nxt       = '0;
    start_nxt      = 1'b0;
    rcp_ip_nxt     = rcp_ip;
    rcp_mac_nxt    = rcp_mac;
    rcp_msg_nxt    = rcp_msg;
    tx_err_nxt     = tx_err;
    case (state)
      IDLE: begin
        // Holding off while REQ_DONE is high gives requesters a cycle to re-request.
        if (ARB_ENABLE && READY_FOR_SEND && win_found && (done == '0)) begin
          state_nxt       = START;
          accept_nxt[win] = 1'b1;
          start_nxt       = 1'b1;
          rcp_ip_nxt      = REQ_IP_ADDRESS[32*int'(win) +: 32];
          rcp_mac_nxt     = REQ_MAC_ADDRESS[48*int'(win) +: 48];
          rcp_msg_nxt     = REQ_MESSAGE[10*int'(win) +: 10];
          grant_nxt       = win;
          last_grant_nxt  = win;
        end
      end
      START: begin
        state_nxt = WAIT_BUSY;
        cnt_nxt   = '0;
      end
      WAIT_BUSY: begin
        if (!READY_FOR_SEND) begin
          state_nxt = WAIT_DONE;
        end else if (cnt == CW'(BUSY_TIMEOUT - 2)) begin
          tx_err_nxt      = 1'b1;
          done_nxt[grant] = 1'b1;
          state_nxt       = IDLE;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      WAIT_DONE: begin
        if (READY_FOR_SEND) begin
          done_nxt[grant] = 1'b1;
          state_nxt       = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESET) begin
    if (!ARESET) begin
      state      <= IDLE;
      last_grant <= GW'(NUM_REQ - 1);
      grant      <= '0;
      cnt        <= '0;
      accept     <= '0;
      done       <= '0;
      start      <= 1'b0;
      rcp_ip     <= '0;
      rcp_mac    <= '0;
      rcp_msg    <= '0;
      tx_err     <= 1'b0;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
      grant      <= grant_nxt;
      cnt        <= cnt_nxt;
      accept     <= accept_nxt;
      done       <= done_nxt;
      start      <= start_nxt;
      rcp_ip     <= rcp_ip_nxt;
      rcp_mac    <= rcp_mac_nxt;
      rcp_msg    <= rcp_msg_nxt;
      tx_err     <= tx_err_nxt;
    end
  end

  assign REQ_ACCEPT            = accept;
  assign REQ_DONE              = done;
  assign START_IP_TXN          = start;
  assign RECIPIENT_IP_ADDRESS  = rcp_ip;
  assign RECIPIENT_MAC_ADDRESS = rcp_mac;
  assign RECIPIENT_MESSAGE     = rcp_msg;
  assign GRANT_ID              = grant;
  assign ARB_BUSY              = (state != IDLE);
  assign TX_ERROR              = tx_err;

endmodule

`default_nettype wire

// File: tb/tb_ip_tx_arbiter.sv
// tb_ip_tx_arbiter: scoreboard bench for ip_tx_arbiter with a behavioural ip_packet_tx model.
`timescale 1ns/1ps
`default_nettype none

module tb_ip_tx_arbiter;
  localparam int NUM_REQ      = 2;
  localparam int BUSY_TIMEOUT = 16;
  localparam int FRAME_BYTES  = 36;

  logic                  ACLK = 1'b0;
  logic                  ARESET;
  logic                  ARB_ENABLE;
  logic [NUM_REQ-1:0]    REQ_VALID;
  logic [32*NUM_REQ-1:0] REQ_IP_ADDRESS;
  logic [48*NUM_REQ-1:0] REQ_MAC_ADDRESS;
  logic [10*NUM_REQ-1:0] REQ_MESSAGE;
  logic [NUM_REQ-1:0]    REQ_ACCEPT;
  logic [NUM_REQ-1:0]    REQ_DONE;
  logic [31:0]           RECIPIENT_IP_ADDRESS;
  logic [47:0]           RECIPIENT_MAC_ADDRESS;
  logic [9:0]            RECIPIENT_MESSAGE;
  logic                  START_IP_TXN;
  logic                  READY_FOR_SEND;
  logic [0:0]            GRANT_ID;
  logic                  ARB_BUSY;
  logic                  TX_ERROR;

  ip_tx_arbiter #(.NUM_REQ(NUM_REQ), .BUSY_TIMEOUT(BUSY_TIMEOUT)) dut (
    .ACLK(ACLK), .ARESET(ARESET), .ARB_ENABLE(ARB_ENABLE), .REQ_VALID(REQ_VALID),
    .REQ_IP_ADDRESS(REQ_IP_ADDRESS), .REQ_MAC_ADDRESS(REQ_MAC_ADDRESS),
    .REQ_MESSAGE(REQ_MESSAGE), .REQ_ACCEPT(REQ_ACCEPT), .REQ_DONE(REQ_DONE),
    .RECIPIENT_IP_ADDRESS(RECIPIENT_IP_ADDRESS), .RECIPIENT_MAC_ADDRESS(RECIPIENT_MAC_ADDRESS),
    .RECIPIENT_MESSAGE(RECIPIENT_MESSAGE), .START_IP_TXN(START_IP_TXN),
    .READY_FOR_SEND(READY_FOR_SEND), .GRANT_ID(GRANT_ID), .ARB_BUSY(ARB_BUSY),
    .TX_ERROR(TX_ERROR)
  );

  always #5 ACLK = ~ACLK;

  typedef struct {
    int          id;
    logic [31:0] ip;
    logic [47:0] mac;
    logic [9:0]  msg;
  } acc_t;

  typedef struct {
    int   id;
    logic err;
    logic tmo;
  } done_t;

  acc_t        acc_q[$];
  done_t       done_q[$];
  logic [31:0] f_ip  [NUM_REQ];
  logic [47:0] f_mac [NUM_REQ];
  logic [9:0]  f_msg [NUM_REQ];

  int errors = 0, checks = 0;
  int cyc = 0;
  int n_acc = 0, n_done = 0, tot_acc = 0, tot_done = 0;
  int acc_cyc = 0, last_done_cyc = -100, rise_cyc = -100;
  logic stub, mac_ready;

  always @(posedge ACLK) cyc <= cyc + 1;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(int id, logic err, logic tmo);
    acc_t  a;
    done_t d;
    a.id = id; a.ip = f_ip[id]; a.mac = f_mac[id]; a.msg = f_msg[id];
    d.id = id; d.err = err; d.tmo = tmo;
    acc_q.push_back(a);
    done_q.push_back(d);
    tot_acc++;
    tot_done++;
  endtask

  task automatic wait_acc(int max);
    int t = 0;
    while (n_acc < tot_acc && t < max) begin @(negedge ACLK); #1; t++; end
    if (n_acc < tot_acc) begin
      checks++; errors++;
      $display("FAIL wait_accept: got %0d accepts, expected %0d", n_acc, tot_acc);
    end
  endtask

  task automatic wait_done(int max);
    int t = 0;
    while (n_done < tot_done && t < max) begin @(negedge ACLK); #1; t++; end
    if (n_done < tot_done) begin
      checks++; errors++;
      $display("FAIL wait_done: got %0d dones, expected %0d", n_done, tot_done);
    end
  endtask

  task automatic wait_engine_busy(int max);
    int t = 0;
    while (READY_FOR_SEND && t < max) begin @(negedge ACLK); #1; t++; end
    chk("engine_went_busy", READY_FOR_SEND, 1'b0);
  endtask

  task automatic reset_checks(string tag);
    chk({tag, "_accept"}, REQ_ACCEPT, 0);
    chk({tag, "_done"}, REQ_DONE, 0);
    chk({tag, "_start"}, START_IP_TXN, 0);
    chk({tag, "_ip"}, RECIPIENT_IP_ADDRESS, 0);
    chk({tag, "_mac"}, RECIPIENT_MAC_ADDRESS, 0);
    chk({tag, "_msg"}, RECIPIENT_MESSAGE, 0);
    chk({tag, "_grant"}, GRANT_ID, 0);
    chk({tag, "_busy"}, ARB_BUSY, 0);
    chk({tag, "_txerr"}, TX_ERROR, 0);
  endtask

  // Engine model: drops READY one cycle after the start pulse, then needs FRAME_BYTES beats with mac_ready high.
  initial begin
    int nb;
    READY_FOR_SEND = 1'b1;
    forever begin
      @(negedge ACLK);
      if (START_IP_TXN && !stub) begin
        @(negedge ACLK);
        READY_FOR_SEND = 1'b0;
        nb = 0;
        while (nb < FRAME_BYTES) begin
          @(negedge ACLK);
          if (mac_ready) nb++;
        end
        READY_FOR_SEND = 1'b1;
        rise_cyc = cyc;
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT shows an accept or a done.
  initial begin
    acc_t  a;
    done_t d;
    forever begin
      @(negedge ACLK);
      if (ARESET !== 1'b1) continue;
      if (|REQ_ACCEPT) begin
        n_acc++;
        chk("accept_done_overlap", REQ_DONE, 0);
        if (acc_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_accept: got %b, expected none", REQ_ACCEPT);
        end else begin
          a = acc_q.pop_front();
          chk("accept_onehot", REQ_ACCEPT, 64'(1) << a.id);
          chk("start_with_accept", START_IP_TXN, 1);
          chk("recipient_ip", RECIPIENT_IP_ADDRESS, a.ip);
          chk("recipient_mac", RECIPIENT_MAC_ADDRESS, a.mac);
          chk("recipient_msg", RECIPIENT_MESSAGE, a.msg);
          chk("grant_id", GRANT_ID, a.id);
          chk("start_gap_ge2", (cyc - last_done_cyc) >= 2, 1);
          acc_cyc = cyc;
        end
      end else if (START_IP_TXN) begin
        checks++; errors++;
        $display("FAIL start_without_accept: got start=1, expected 0");
      end
      if (|REQ_DONE) begin
        n_done++;
        if (done_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done: got %b, expected none", REQ_DONE);
        end else begin
          d = done_q.pop_front();
          chk("done_onehot", REQ_DONE, 64'(1) << d.id);
          chk("done_txerr", TX_ERROR, d.err);
          chk("done_busy_clear", ARB_BUSY, 0);
          if (d.tmo) chk("timeout_latency", cyc - acc_cyc, BUSY_TIMEOUT);
          else       chk("done_after_ready", cyc, rise_cyc + 1);
        end
        last_done_cyc = cyc;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before 200us");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int acc_before;
    f_ip[0] = 32'hdeadbeef; f_mac[0] = 48'h32dabbadebd5; f_msg[0] = 10'h1ff;
    f_ip[1] = 32'hc0a80001; f_mac[1] = 48'h0a1b2c3d4e5f; f_msg[1] = 10'h155;
    REQ_IP_ADDRESS  = {f_ip[1], f_ip[0]};
    REQ_MAC_ADDRESS = {f_mac[1], f_mac[0]};
    REQ_MESSAGE     = {f_msg[1], f_msg[0]};
    ARESET = 1'b1; ARB_ENABLE = 1'b1; REQ_VALID = '0; mac_ready = 1'b1; stub = 1'b0;
    #1 ARESET = 1'b0;
    repeat (3) @(negedge ACLK);
    #1 reset_checks("reset");
    ARESET = 1'b1;

    // Contention from reset: requester 0 first, then strict alternation.
    push(0, 1'b0, 1'b0); push(1, 1'b0, 1'b0); push(0, 1'b0, 1'b0); push(1, 1'b0, 1'b0);
    REQ_VALID = 2'b11;
    wait_acc(1000);
    REQ_VALID = 2'b00;
    wait_done(200);

    // Single request from requester 0.
    push(0, 1'b0, 1'b0);
    REQ_VALID = 2'b01;
    wait_acc(50);
    REQ_VALID = 2'b00;
    wait_done(200);

    // Backpressure mid-frame.
    push(0, 1'b0, 1'b0);
    REQ_VALID = 2'b01;
    wait_acc(50);
    REQ_VALID = 2'b00;
    wait_engine_busy(20);
    repeat (10) @(negedge ACLK);
    #1 mac_ready = 1'b0;
    repeat (5) begin
      @(negedge ACLK); #1;
      chk("bp_busy", ARB_BUSY, 1);
      chk("bp_no_start", START_IP_TXN, 0);
      chk("bp_txerr", TX_ERROR, 0);
    end
    mac_ready = 1'b1;
    wait_done(200);

    // Enable gating: disable right after the start pulse with requester 1 waiting.
    push(0, 1'b0, 1'b0);
    REQ_VALID = 2'b01;
    wait_acc(50);
    ARB_ENABLE = 1'b0;
    REQ_VALID  = 2'b10;
    wait_done(200);
    acc_before = n_acc;
    repeat (10) @(negedge ACLK);
    #1;
    chk("no_grant_disabled", n_acc, acc_before);
    chk("idle_disabled", ARB_BUSY, 0);
    push(1, 1'b0, 1'b0);
    ARB_ENABLE = 1'b1;
    for (int t = 0; t < 2 && n_acc == acc_before; t++) begin @(negedge ACLK); #1; end
    chk("grant_after_enable", n_acc > acc_before, 1);
    REQ_VALID = 2'b00;
    wait_done(200);

    // Timeout: engine ignores the start pulse.
    stub = 1'b1;
    push(0, 1'b1, 1'b1);
    REQ_VALID = 2'b01;
    wait_acc(50);
    REQ_VALID = 2'b00;
    wait_done(50);
    stub = 1'b0;
    repeat (2) @(negedge ACLK);

    // Error flag is sticky across a good packet.
    push(1, 1'b1, 1'b0);
    REQ_VALID = 2'b10;
    wait_acc(50);
    REQ_VALID = 2'b00;
    wait_done(200);
    #1 chk("txerr_sticky", TX_ERROR, 1);

    // Reset while in WAIT_DONE: abandoned silently.
    push(0, 1'b1, 1'b0);
    REQ_VALID = 2'b01;
    wait_acc(50);
    REQ_VALID = 2'b00;
    wait_engine_busy(20);
    repeat (5) @(negedge ACLK);
    void'(done_q.pop_back());
    tot_done--;
    #2 ARESET = 1'b0;
    #1 reset_checks("midreset");
    @(negedge ACLK);
    #1 ARESET = 1'b1;
    push(0, 1'b0, 1'b0);
    REQ_VALID = 2'b11;
    wait_acc(200);
    REQ_VALID = 2'b00;
    wait_done(200);

    repeat (5) @(negedge ACLK);
    #1;
    chk("accept_queue_empty", acc_q.size(), 0);
    chk("done_queue_empty", done_q.size(), 0);
    chk("done_total", n_done, tot_done);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
